subleq_program_loader: RTL and testbench



---
 rtl/subleq_program_loader.sv | 196 +++++++++++++++++++
 tb/tb_subleq_program_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_program_loader.sv
// subleq_program_loader
// Boot stage for the SUBLEQ uniprocessor. Receives a little-endian byte
// stream (4-byte word count N, then N 4-byte words) over valid/ready. Words
// are written to word memory from address 0 upward. The processor is held in
// reset until the whole image has been written.
//
// Optional feature (macro LOADER_CHECKSUM_EN): after the data words, a 4-byte
// LE checksum is accepted. The checksum is the mod-2^32 sum of all data
// words. A mismatch lands in ERR, and the processor stays in reset.
//
// Ports:
//   clock      system clock
//   rst        synchronous active-high reset
//   in_valid   in_byte holds a valid byte
//   in_ready   loader accepts a byte this cycle (decoded from state)
//   in_byte    image byte stream
//   mem_addr   memory write word address (registered)
//   mem_wdata  memory write data (registered)
//   mem_we     one-cycle memory write strobe (registered)
//   proc_rst   processor reset, high until load completes (registered)
//   load_done  sticky: image loaded, processor released (registered)
//   load_error sticky: image rejected, processor held (registered)
module subleq_program_loader #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              proc_rst,
    output logic              load_done,
    output logic              load_error
);

    localparam int unsigned CNT_W = $clog2(MEM_WORDS + 1);

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CSUM  = 3'd5
`endif
    } state_t;

    // State entered once the last data word (or an empty header) is handled
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CSUM;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       shift_q, shift_d;
    logic [31:0]       n_q, n_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_we_d, proc_rst_d, load_done_d, load_error_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [31:0]       mem_wdata_d;
    logic              ready_state;
    logic              accept;
    logic [31:0]       assembled;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
`endif

    // Byte acceptance depends on state only; held off while rst is high
`ifdef LOADER_CHECKSUM_EN
    assign ready_state = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
    assign ready_state = (state_q == S_HDR) || (state_q == S_DATA);
`endif
    assign in_ready  = ready_state && !rst;
    assign accept    = in_valid && in_ready;
    // Incoming byte lands on top, so after four bytes the first is bits 7:0
    assign assembled = {in_byte, shift_q};

    // State register and registered outputs
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_HDR;
            byte_idx_q <= 2'd0;
            shift_q    <= 24'd0;
            n_q        <= 32'd0;
            cnt_q      <= CNT_W'(0);
            mem_we     <= 1'b0;
            mem_addr   <= ADDR_W'(0);
            mem_wdata  <= 32'd0;
            proc_rst   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            proc_rst   <= proc_rst_d;
            load_done  <= load_done_d;
            load_error <= load_error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        if (accept) begin
            shift_d    = assembled[31:8];
            byte_idx_d = byte_idx_q + 2'd1;
        end

        case (state_q)
            S_HDR: begin
`ifdef LOADER_CHECKSUM_EN
                sum_d = 32'd0;
`endif
                if (accept && (byte_idx_q == 2'd3)) begin
                    n_d   = assembled;
                    cnt_d = CNT_W'(0);
                    if (assembled > 32'(MEM_WORDS)) begin
                        state_d = S_ERR;
                    end else if (assembled == 32'd0) begin
                        state_d = S_AFTER_DATA;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Strobe is registered so it lands the cycle after the 4th byte
                if (accept && (byte_idx_q == 2'd3)) begin
                    state_d     = S_WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(cnt_q);
                    mem_wdata_d = assembled;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                sum_d = sum_q + mem_wdata;
`endif
                // Full-width compare so no N can alias onto the counter width
                if ((32'(cnt_q) + 32'd1) == n_q) begin
                    state_d = S_AFTER_DATA;
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept && (byte_idx_q == 2'd3)) begin
                    state_d = (assembled == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase

        proc_rst_d   = (state_d != S_DONE);
        load_done_d  = (state_d == S_DONE);
        load_error_d = (state_d == S_ERR);
    end

endmodule

// File: tb/tb_subleq_program_loader.sv
// Bench for subleq_program_loader. The expected memory writes and final status
// are derived from the image contents. A monitor pops the expected writes off a
// queue whenever mem_we is seen. Define LOADER_CHECKSUM_EN for both the bench
// and the RTL to exercise the checksum variant.
module tb_subleq_program_loader;

    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned ADDR_W    = 32;

    logic              clock = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_byte;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              proc_rst;
    logic              load_done;
    logic              load_error;

    subleq_program_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .proc_rst   (proc_rst),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write must match the head of the expected queue
    always @(negedge clock) begin
        if (!rst && mem_we) begin
            wr_t e;
            chk("ready_low_in_write", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), e.addr);
                chk("wr_data", mem_wdata, e.data);
            end
        end
    end

    // Offer a byte after 'gap' idle cycles; return once it has been accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        repeat (gap) begin
            @(negedge clock);
            in_valid = 1'b0;
            in_byte  = 8'($urandom);
        end
        @(negedge clock);
        in_valid = 1'b1;
        in_byte  = b;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: byte 0x%02h never accepted", b);
        end else begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gmin, input int gmax);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], $urandom_range(gmax, gmin));
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        exp_q.delete();
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);
    endtask

    // Loads img[0..n-1] with header n and checks the end status
    task automatic run_image(input logic [31:0] n, input int gmin, input int gmax, input bit bad_csum);
        logic [31:0] sum;
        bit          exp_err;
        int          cyc;
        sum     = 32'd0;
        exp_err = (n > 32'(MEM_WORDS));
        send_word(n, gmin, gmax);
        if (!exp_err) begin
            for (int k = 0; k < int'(n); k++) begin
                exp_q.push_back({32'(k), img[k]});
                sum = sum + img[k];
                send_word(img[k], gmin, gmax);
                @(negedge clock);
                chk("we_latency", 32'(mem_we), 32'd1);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (!exp_err) begin
            send_word(bad_csum ? sum + 32'd1 : sum, gmin, gmax);
            exp_err = bad_csum;
        end
`else
        if (bad_csum) exp_err = exp_err;
`endif
        cyc = 0;
        while (!(load_done || load_error) && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
`ifndef LOADER_CHECKSUM_EN
        chk("status_cycles", 32'(cyc), (exp_err || n == 32'd0) ? 32'd0 : 32'd1);
`endif
        chk("load_done",  32'(load_done),  exp_err ? 32'd0 : 32'd1);
        chk("load_error", 32'(load_error), exp_err ? 32'd1 : 32'd0);
        chk("proc_rst",   32'(proc_rst),   exp_err ? 32'd1 : 32'd0);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        // Further traffic must be ignored
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_byte  = 8'($urandom);
            #1;
            chk("ready_low_at_end", 32'(in_ready), 32'd0);
        end
        @(negedge clock);
        in_valid = 1'b0;
        chk("status_sticky", {30'd0, load_done, load_error}, exp_err ? 32'd1 : 32'd2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'd0;
        repeat (2) @(negedge clock);
        // Reset values, sampled while rst is still high
        chk("rst_in_ready",   32'(in_ready),   32'd0);
        chk("rst_mem_we",     32'(mem_we),     32'd0);
        chk("rst_mem_addr",   32'(mem_addr),   32'd0);
        chk("rst_mem_wdata",  mem_wdata,       32'd0);
        chk("rst_proc_rst",   32'(proc_rst),   32'd1);
        chk("rst_load_done",  32'(load_done),  32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);

        // Two words, in_valid held high
        do_reset();
        img = {32'h11223344, 32'hAABBCCDD};
        run_image(32'd2, 0, 0, 1'b0);

        // Same image with in_valid toggling
        do_reset();
        run_image(32'd2, 1, 1, 1'b0);

        // Empty image
        do_reset();
        img.delete();
        run_image(32'd0, 0, 0, 1'b0);

        // Oversize header is rejected, exact maximum accepted
        do_reset();
        run_image(32'(MEM_WORDS + 1), 0, 0, 1'b0);
        do_reset();
        img.delete();
        for (int k = 0; k < int'(MEM_WORDS); k++) img.push_back($urandom);
        run_image(32'(MEM_WORDS), 0, 0, 1'b0);

        // Reset in the middle of a load, then reload
        do_reset();
        img = {32'h11223344, 32'hAABBCCDD};
        exp_q.push_back({32'd0, img[0]});
        send_word(32'd2, 0, 0);
        send_word(img[0], 0, 0);
        send_byte(img[1][7:0], 0);
        send_byte(img[1][15:8], 0);
        @(negedge clock);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("midrst_in_ready",   32'(in_ready),   32'd0);
        chk("midrst_mem_we",     32'(mem_we),     32'd0);
        chk("midrst_mem_addr",   32'(mem_addr),   32'd0);
        chk("midrst_mem_wdata",  mem_wdata,       32'd0);
        chk("midrst_proc_rst",   32'(proc_rst),   32'd1);
        chk("midrst_load_done",  32'(load_done),  32'd0);
        chk("midrst_load_error", 32'(load_error), 32'd0);
        chk("midrst_word0_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        #1;
        chk("midrst_ready_release", 32'(in_ready), 32'd1);
        img = {32'hCAFEF00D};
        run_image(32'd1, 0, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Sum of 0xFFFFFFFF and 0x2 wraps to 0x1
        do_reset();
        img = {32'hFFFFFFFF, 32'h00000002};
        run_image(32'd2, 0, 0, 1'b0);
        do_reset();
        run_image(32'd2, 0, 0, 1'b1);
`endif

        // Randomised images
        for (int t = 0; t < 12; t++) begin
            int unsigned n;
            do_reset();
            n = $urandom_range(6, 0);
            img.delete();
            for (int k = 0; k < int'(n); k++) img.push_back($urandom);
            run_image(32'(n), 0, 2, 1'($urandom_range(1, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
